// File: rtl/ltpi_pkg.sv
// Shared types and default thresholds for the LTPI target PHY management path.
package ltpi_pkg;

  typedef enum logic [3:0] {
    INIT                       = 4'd0,
    COMMA_HUNTING              = 4'd1,
    WAIT_LINK_DETECT_LOCKED    = 4'd2,
    WAIT_LINK_SPEED_LOCKED     = 4'd3,
    LINK_SPEED_CHANGE          = 4'd4,
    WAIT_LINK_ADVERTISE_LOCKED = 4'd5,
    WAIT_IN_ADVERTISE          = 4'd6,
    CONFIGURATION_OR_ACCEPT    = 4'd7,
    OPERATIONAL                = 4'd8,
    OPERATIONAL_RESET          = 4'd9,
    LINK_LOST_ERR              = 4'd10
  } rstate_t;

  typedef enum logic [3:0] {
    DETECT       = 4'd0,
    SPEED        = 4'd1,
    ADVERTISE    = 4'd2,
    CONFIGURE    = 4'd3,
    ACCEPT       = 4'd4,
    DEFAULT_IO   = 4'd5,
    DEFAULT_DATA = 4'd6
  } frame_type_t;

  localparam int DEF_DETECT_LOCK_CNT = 7;
  localparam int DEF_TX_DETECT_CNT   = 255;
  localparam int DEF_SPEED_LOCK_CNT  = 7;
  localparam int DEF_ADV_LOCK_CNT    = 7;
  localparam int DEF_CRC_LOSS_CNT    = 3;
  localparam int DEF_SPEED_TMO_CYC   = 60000;
  localparam int DEF_FRM_LOST_CYC    = 64;

  // States without a frame-type restriction accept everything.
  function automatic logic frame_legal(rstate_t st, frame_type_t ft);
    case (st)
      WAIT_LINK_DETECT_LOCKED, WAIT_LINK_SPEED_LOCKED:
        return (ft == DETECT) || (ft == SPEED);
      WAIT_LINK_ADVERTISE_LOCKED, WAIT_IN_ADVERTISE, CONFIGURATION_OR_ACCEPT:
        return (ft == ADVERTISE) || (ft == CONFIGURE) || (ft == ACCEPT);
      OPERATIONAL, OPERATIONAL_RESET:
        return (ft == DEFAULT_IO) || (ft == DEFAULT_DATA);
      default:
        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mgmt_consec_cnt.sv
// Saturating consecutive-event counter; hit reports that the count is at MAX after this cycle.
module mgmt_consec_cnt #(
  parameter int MAX = 7,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  input  logic rst_cnt,
  output logic hit
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr || rst_cnt)
      cnt_nxt = '0;
    else if (inc && (cnt != W'(MAX)))
      cnt_nxt = cnt + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

  // Next-value compare lets the owner register a sticky flag on the same edge.
  assign hit = (cnt_nxt == W'(MAX));

endmodule

// File: rtl/mgmt_phy_target_lock_mon.sv
// RX lock / timeout / error qualifiers feeding the LTPI target PHY management FSM.
module mgmt_phy_target_lock_mon
  import ltpi_pkg::*;
#(
  parameter int DETECT_LOCK_CNT = DEF_DETECT_LOCK_CNT,
  parameter int TX_DETECT_CNT   = DEF_TX_DETECT_CNT,
  parameter int SPEED_LOCK_CNT  = DEF_SPEED_LOCK_CNT,
  parameter int ADV_LOCK_CNT    = DEF_ADV_LOCK_CNT,
  parameter int CRC_LOSS_CNT    = DEF_CRC_LOSS_CNT,
  parameter int SPEED_TMO_CYC   = DEF_SPEED_TMO_CYC,
  parameter int FRM_LOST_CYC    = DEF_FRM_LOST_CYC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  rstate_t     LTPI_link_ST,
  input  logic        rx_frm_valid,
  input  logic        rx_frm_crc_err,
  input  frame_type_t rx_frm_type,
  input  logic        tx_frm_done,
  output logic        link_detect_locked,
  output logic        transmited_255_detect_frm,
  output logic        link_speed_locked,
  output logic        link_speed_timeout_detect,
  output logic        advertise_locked,
  output logic        crc_consec_loss,
  output logic        frame_crc_err,
  output logic        unexpected_frame_error,
  output logic        operational_frm_lost_error
);

  localparam int TMO_W = $clog2(SPEED_TMO_CYC + 1);
  localparam int GAP_W = $clog2(FRM_LOST_CYC + 2);

  rstate_t          st_prev;
  logic             chg, vld, good, bad, tx;
  logic             in_det, in_spd, in_adv, crc_act;
  logic             det_inc, spd_inc, adv_inc;
  logic             det_hit, spd_hit, adv_hit, crc_hit, tx_hit;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;

  // Events in the cycle the state changes belong to the old state and are dropped.
  assign chg  = (LTPI_link_ST != st_prev);
  assign vld  = rx_frm_valid & ~chg;
  assign good = vld & ~rx_frm_crc_err;
  assign bad  = vld & rx_frm_crc_err;
  assign tx   = tx_frm_done & ~chg;

  assign in_det  = (LTPI_link_ST == WAIT_LINK_DETECT_LOCKED);
  assign in_spd  = (LTPI_link_ST == WAIT_LINK_SPEED_LOCKED);
  assign in_adv  = (LTPI_link_ST == WAIT_LINK_ADVERTISE_LOCKED) ||
                   (LTPI_link_ST == WAIT_IN_ADVERTISE);
  assign crc_act = !((LTPI_link_ST == INIT) || (LTPI_link_ST == COMMA_HUNTING) ||
                     (LTPI_link_ST == LINK_LOST_ERR) || (LTPI_link_ST == LINK_SPEED_CHANGE));

  assign det_inc = in_det & good & (rx_frm_type == DETECT);
  assign spd_inc = in_spd & good & (rx_frm_type == SPEED);
  assign adv_inc = in_adv & good & (rx_frm_type == ADVERTISE);

  mgmt_consec_cnt #(.MAX(DETECT_LOCK_CNT)) u_det_cnt (
    .clk(clk), .reset_n(reset_n), .clr(chg),
    .inc(det_inc), .rst_cnt(in_det & vld & ~det_inc), .hit(det_hit));

  mgmt_consec_cnt #(.MAX(SPEED_LOCK_CNT)) u_spd_cnt (
    .clk(clk), .reset_n(reset_n), .clr(chg),
    .inc(spd_inc), .rst_cnt(in_spd & vld & ~spd_inc), .hit(spd_hit));

  mgmt_consec_cnt #(.MAX(ADV_LOCK_CNT)) u_adv_cnt (
    .clk(clk), .reset_n(reset_n), .clr(chg),
    .inc(adv_inc), .rst_cnt(in_adv & vld & ~adv_inc), .hit(adv_hit));

  mgmt_consec_cnt #(.MAX(CRC_LOSS_CNT)) u_crc_cnt (
    .clk(clk), .reset_n(reset_n), .clr(chg),
    .inc(crc_act & bad), .rst_cnt(crc_act & good), .hit(crc_hit));

  mgmt_consec_cnt #(.MAX(TX_DETECT_CNT)) u_tx_cnt (
    .clk(clk), .reset_n(reset_n), .clr(chg),
    .inc(in_det & tx), .rst_cnt(1'b0), .hit(tx_hit));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_prev                    <= INIT;
      tmo_cnt                    <= '0;
      gap_cnt                    <= '0;
      link_detect_locked         <= 1'b0;
      transmited_255_detect_frm  <= 1'b0;
      link_speed_locked          <= 1'b0;
      link_speed_timeout_detect  <= 1'b0;
      advertise_locked           <= 1'b0;
      crc_consec_loss            <= 1'b0;
      frame_crc_err              <= 1'b0;
      unexpected_frame_error     <= 1'b0;
      operational_frm_lost_error <= 1'b0;
    end else begin
      st_prev                <= LTPI_link_ST;
      frame_crc_err          <= bad;
      unexpected_frame_error <= good & ~frame_legal(LTPI_link_ST, rx_frm_type);
      if (chg) begin
        tmo_cnt                    <= '0;
        gap_cnt                    <= '0;
        link_detect_locked         <= 1'b0;
        transmited_255_detect_frm  <= 1'b0;
        link_speed_locked          <= 1'b0;
        link_speed_timeout_detect  <= 1'b0;
        advertise_locked           <= 1'b0;
        crc_consec_loss            <= 1'b0;
        operational_frm_lost_error <= 1'b0;
      end else begin
        link_detect_locked        <= link_detect_locked | det_hit;
        transmited_255_detect_frm <= transmited_255_detect_frm | tx_hit;
        link_speed_locked         <= link_speed_locked | spd_hit;
        advertise_locked          <= advertise_locked | adv_hit;
        crc_consec_loss           <= crc_consec_loss | crc_hit;
        // A lock landing on the expiry cycle suppresses the timeout.
        if (in_spd && !link_speed_locked) begin
          if ((tmo_cnt == TMO_W'(SPEED_TMO_CYC - 1)) && !spd_hit)
            link_speed_timeout_detect <= 1'b1;
          if (tmo_cnt != TMO_W'(SPEED_TMO_CYC))
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        if (LTPI_link_ST == OPERATIONAL) begin
          if (vld) begin
            gap_cnt <= '0;
          end else begin
            if (gap_cnt != GAP_W'(FRM_LOST_CYC + 1))
              gap_cnt <= gap_cnt + GAP_W'(1);
            if (gap_cnt >= GAP_W'(FRM_LOST_CYC))
              operational_frm_lost_error <= 1'b1;
          end
        end
      end
    end
  end

endmodule
